// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM encoding and slice width for the nibble-serial add/sub
package addsub_pkg;

  // Width of one datapath slice; the shared adder is always this wide.
  localparam int SLICE_W = 4;

  // Controller states: waiting, stepping through slices, reporting completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub4.sv
// rtl/addsub4.sv - 4-bit ripple adder exposing the carry into its top bit
module addsub4
  import addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W-2:0] lo_sum;
  logic               hi_sum;

  // Split at bit 3 so the carry into the MSB is available for overflow detection.
  always_comb begin
    {c3, lo_sum} = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
    {cout, hi_sum} = {1'b0, a[SLICE_W-1]} + {1'b0, b[SLICE_W-1]} + {1'b0, c3};
    s = {hi_sum, lo_sum};
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - nibble-serial adder/subtractor with IDLE/RUN/DONE control
module nibble_serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;       // B already inverted for subtraction
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_cin, sl_cout, sl_c3;
  logic               last_slice;

  // Select the current slice of both operands for the shared adder.
  always_comb begin
    sl_a       = a_q[idx_q*SLICE_W +: SLICE_W];
    sl_b       = b_q[idx_q*SLICE_W +: SLICE_W];
    // Slice 0 takes the latched operation as carry-in (the +1 of two's-complement negate).
    sl_cin     = (idx_q == '0) ? sub_q : carry_q;
    last_slice = (idx_q == IW'(NIBBLES - 1));
  end

  addsub4 u_addsub4 (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .s    (sl_s),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  // State register and datapath registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update: accept in IDLE/DONE, one slice per RUN cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {W{op_sub}};
          sub_d   = op_sub;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          ovf_d   = sl_c3 ^ sl_cout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status and results come straight from registers so reset clears them at once.
  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
    result = result_q;
    cout   = carry_q;
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - directed self-checking bench for nibble_serial_addsub_ctrl
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int n_cmp;
  int n_err;
  int done_cnt;

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which done is high, sampled mid-cycle.
  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until done is high, sampling #1 after each edge; returns edges waited.
  task automatic wait_done(output int edges, output int bcnt);
    edges = 0;
    bcnt  = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sub, input logic [15:0] er, input logic ec, input logic eo);
    int edges, bcnt, base;
    @(negedge clk);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = done_cnt;
    wait_done(edges, bcnt);
    // edges counted from the accept edge inclusive
    check_eq({tag, "_latency"}, edges + 1, 5);
    check_eq({tag, "_busy_cycles"}, bcnt, 4);
    check_eq({tag, "_result"}, result, er);
    check_eq({tag, "_cout"}, cout, ec);
    check_eq({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
    check_eq({tag, "_done_low"}, done, 1'b0);
    check_eq({tag, "_hold"}, {ovf, cout, result}, {eo, ec, er});
    check_eq({tag, "_done_pulses"}, done_cnt - base, 1);
  endtask

  initial begin
    int edges, bcnt, base;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {busy, done, cout, ovf, result}, 20'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",      16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_zero", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("add_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Busy guard: a new start with different operands mid-run is ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    base = done_cnt;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(edges, bcnt);
    check_eq("guard_result", result, 16'h2143);
    check_eq("guard_cout", cout, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("guard_done_pulses", done_cnt - base, 1);
    check_eq("guard_idle", busy, 1'b0);

    // Back-to-back: start held through the done cycle chains a second operation.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    base = done_cnt;
    wait_done(edges, bcnt);
    check_eq("b2b_first_done", done, 1'b1);
    check_eq("b2b_first_result", result, 16'h0007);
    a = 16'h0010; b = 16'h0001; op_sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_no_idle", {busy, done}, 2'b10);
    wait_done(edges, bcnt);
    check_eq("b2b_second_latency", edges + 1, 5);
    check_eq("b2b_second_result", result, 16'h000F);
    check_eq("b2b_second_cout", cout, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("b2b_done_pulses", done_cnt - base, 2);

    // Reset in the third RUN cycle clears everything without waiting for a clock edge.
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("midop_partial", result, 16'h0043);
    rst_n = 1'b0;
    #1;
    check_eq("midop_reset_outputs", {busy, done, cout, ovf, result}, 20'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
